// File: rtl/ntt_pkg.sv
// Shared Kyber NTT constants, mode and scheduler state types.
// Revision: 1.0
`default_nettype none

package ntt_pkg;

  localparam int KYBER_N          = 256;
  localparam int KYBER_Q          = 3329;
  localparam int NTT_LAYERS       = 7;
  localparam int NTT_BF_PER_LAYER = 128;

  typedef enum logic {
    NTT_FWD = 1'b0,
    NTT_INV = 1'b1
  } ntt_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ntt_state_e;

endpackage

`default_nettype wire

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator: (mode, layer, bcnt) -> (a, b, twiddle index k).
// Revision: 1.0
`default_nettype none

module ntt_addr_gen
  import ntt_pkg::*;
(
  input  ntt_mode_e  i_mode,
  input  logic [2:0] i_layer,
  input  logic [6:0] i_bcnt,
  output logic [7:0] o_addr_a,
  output logic [7:0] o_addr_b,
  output logic [6:0] o_k
);

  logic [2:0] w_s;
  logic [7:0] w_len;
  logic [6:0] w_blk;
  logic [7:0] w_j;

  always_comb begin
    w_s      = (i_mode == NTT_INV) ? (i_layer + 3'd1) : (3'd7 - i_layer);
    w_len    = 8'd1 << w_s;
    // A block holds len butterflies and spans 2*len coefficients.
    w_blk    = i_bcnt >> w_s;
    w_j      = {1'b0, i_bcnt} & (w_len - 8'd1);
    o_addr_a = ({w_blk, 1'b0} << w_s) | w_j;
    o_addr_b = o_addr_a + w_len;
    // Inverse layer 0: 7-bit (1<<7) is 0, so 0-1-blk wraps to 127-blk as intended.
    if (i_mode == NTT_INV) begin
      o_k = (7'd1 << (3'd7 - i_layer)) - 7'd1 - w_blk;
    end else begin
      o_k = (7'd1 << i_layer) + w_blk;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ntt_sched_ctrl.sv
// Kyber NTT/INTT butterfly scheduler: drives twiddle ROM address, emits ROM-aligned beats.
// Revision: 1.0
`default_nettype none

module ntt_sched_ctrl
  import ntt_pkg::*;
#(
  parameter int BF_LAT    = 4,
  parameter int LAYER_GAP = BF_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic       i_bf_ready,
  output logic [7:0] o_tw_addr,
  output logic       o_bf_valid,
  output logic [7:0] o_addr_a,
  output logic [7:0] o_addr_b,
  output logic       o_bf_inv,
  output logic [2:0] o_layer,
  output logic       o_busy,
  output logic       o_done
);

  localparam int DRAIN_LEN = 1 + BF_LAT;
  localparam int CNT_MAX   = (LAYER_GAP > DRAIN_LEN) ? LAYER_GAP : DRAIN_LEN;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((LAYER_GAP > 0) ? LAYER_GAP - 1 : 0);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN - 1);

  ntt_state_e r_state, w_state_nxt;
  ntt_mode_e  r_mode;
  logic [2:0] r_layer;
  logic [6:0] r_bcnt;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_tw_hold;
  logic       r_bf_valid;
  logic [7:0] r_addr_a;
  logic [7:0] r_addr_b;
  logic       r_bf_inv;

  logic       w_issue;
  logic       w_layer_end;
  logic       w_last_layer;
  logic       w_layer_inc;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [6:0] w_k;
  logic [7:0] w_tw;

  ntt_addr_gen u_addr_gen (
    .i_mode   (r_mode),
    .i_layer  (r_layer),
    .i_bcnt   (r_bcnt),
    .o_addr_a (w_a),
    .o_addr_b (w_b),
    .o_k      (w_k)
  );

  always_comb begin
    w_issue      = (r_state == RUN) && i_bf_ready;
    w_layer_end  = w_issue && (r_bcnt == 7'd127);
    w_last_layer = (r_layer == 3'(NTT_LAYERS - 1));
    w_tw         = {1'(r_mode), w_k};
    w_layer_inc  = 1'b0;
    w_state_nxt  = r_state;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = RUN;
      RUN: begin
        if (w_layer_end) begin
          if (w_last_layer) begin
            w_state_nxt = DRAIN;
          end else if (LAYER_GAP == 0) begin
            w_layer_inc = 1'b1;
          end else begin
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = RUN;
          w_layer_inc = 1'b1;
        end
      end
      DRAIN: if (r_cnt == DRAIN_LAST) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mode     <= NTT_FWD;
      r_layer    <= 3'd0;
      r_bcnt     <= 7'd0;
      r_cnt      <= '0;
      r_tw_hold  <= 8'd0;
      r_bf_valid <= 1'b0;
      r_addr_a   <= 8'd0;
      r_addr_b   <= 8'd0;
      r_bf_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && i_start) begin
        r_mode  <= ntt_mode_e'(i_mode);
        r_layer <= 3'd0;
        r_bcnt  <= 7'd0;
      end
      if (w_layer_inc) r_layer <= r_layer + 3'd1;
      if (((r_state == GAP) || (r_state == DRAIN)) && (w_state_nxt == r_state)) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
      r_bf_valid <= w_issue;
      if (w_issue) begin
        r_bcnt    <= r_bcnt + 7'd1;
        r_tw_hold <= w_tw;
        r_addr_a  <= w_a;
        r_addr_b  <= w_b;
        r_bf_inv  <= 1'(r_mode);
      end
    end
  end

  // ROM samples the live address in the issue cycle; otherwise it sees the last one.
  assign o_tw_addr  = w_issue ? w_tw : r_tw_hold;
  assign o_bf_valid = r_bf_valid;
  assign o_addr_a   = r_addr_a;
  assign o_addr_b   = r_addr_b;
  assign o_bf_inv   = r_bf_inv;
  assign o_layer    = r_layer;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_ntt_sched_ctrl.sv
// Randomised bench for ntt_sched_ctrl against a textbook Kyber NTT loop-nest model.
// Revision: 1.0
`default_nettype none

module tb_ntt_sched_ctrl;

  localparam int BF_LAT    = 4;
  localparam int LAYER_GAP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic       i_mode;
  logic       i_bf_ready;
  logic [7:0] o_tw_addr;
  logic       o_bf_valid;
  logic [7:0] o_addr_a;
  logic [7:0] o_addr_b;
  logic       o_bf_inv;
  logic [2:0] o_layer;
  logic       o_busy;
  logic       o_done;

  always #5 clk = ~clk;

  ntt_sched_ctrl #(.BF_LAT(BF_LAT), .LAYER_GAP(LAYER_GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_bf_ready (i_bf_ready),
    .o_tw_addr  (o_tw_addr),
    .o_bf_valid (o_bf_valid),
    .o_addr_a   (o_addr_a),
    .o_addr_b   (o_addr_b),
    .o_bf_inv   (o_bf_inv),
    .o_layer    (o_layer),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  typedef struct {
    int a;
    int b;
    int tw;
    int inv;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int beats, busy_cyc, dones, last_valid_cyc;
  logic [11:0] rom_dout;

  function automatic logic [11:0] rom_f(input logic [7:0] ad);
    return 12'((int'(ad) * 1729 + 17) % 3329);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_dout <= rom_f(o_tw_addr);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference butterfly order straight from the Kyber ntt()/invntt() loop nests.
  task automatic build(input int m);
    beat_t e;
    int k;
    exp_q.delete();
    if (m == 0) begin
      k = 1;
      for (int len = 128; len >= 2; len = len / 2)
        for (int st = 0; st < 256; st = st + 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            e.a = j; e.b = j + len; e.tw = k; e.inv = 0;
            exp_q.push_back(e);
          end
          k++;
        end
    end else begin
      k = 127;
      for (int len = 2; len <= 128; len = len * 2)
        for (int st = 0; st < 256; st = st + 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            e.a = j; e.b = j + len; e.tw = 128 + k; e.inv = 1;
            exp_q.push_back(e);
          end
          k--;
        end
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (o_busy) busy_cyc++;
      if (o_bf_valid) begin
        beats++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("addr_a", o_addr_a, e.a);
          chk("addr_b", o_addr_b, e.b);
          chk("bf_inv", o_bf_inv, e.inv);
          chk("rom_dout", rom_dout, rom_f(8'(e.tw)));
        end
      end
      if (o_done) begin
        dones++;
        chk("done_latency", cyc - last_valid_cyc, 1 + BF_LAT);
        chk("beats_left_at_done", exp_q.size(), 0);
        chk("busy_at_done", o_busy, 1);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_tw"}, o_tw_addr, 0);
    chk({tag, "_valid"}, o_bf_valid, 0);
    chk({tag, "_a"}, o_addr_a, 0);
    chk({tag, "_b"}, o_addr_b, 0);
    chk({tag, "_inv"}, o_bf_inv, 0);
    chk({tag, "_layer"}, o_layer, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  // style 0: always ready; 1: 10-cycle stall mid layer 3; 2: random ready.
  task automatic run(input int m, input int style, input int exp_busy);
    int  stall_left = 0;
    bit  stalled = 0;
    bit  prev_rdy;
    int  last_tw;
    build(m);
    last_tw  = exp_q[$].tw;
    beats    = 0;
    busy_cyc = 0;
    dones    = 0;
    i_bf_ready = (style == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    i_mode  = 1'(m);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_mode  = ~1'(m);
    chk("busy_rise", o_busy, 1);
    if (i_bf_ready) chk("first_tw", o_tw_addr, exp_q[0].tw);
    prev_rdy = i_bf_ready;
    for (int g = 0; g < 4000 && dones == 0; g++) begin
      @(posedge clk); #1;
      if (!prev_rdy) chk("valid_after_stall", o_bf_valid, 0);
      case (style)
        1: begin
          if (!stalled && beats >= 434) begin
            stalled    = 1;
            stall_left = 10;
          end
          i_bf_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        2: i_bf_ready = ($urandom_range(0, 3) != 0);
        default: i_bf_ready = 1'b1;
      endcase
      prev_rdy = i_bf_ready;
      i_start  = (busy_cyc == 200);
    end
    i_start = 1'b0;
    if (dones == 0) chk("run_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", dones, 1);
    chk("beat_count", beats, 896);
    if (exp_busy >= 0) chk("busy_len", busy_cyc, exp_busy);
    chk("busy_fall", o_busy, 0);
    chk("tw_hold", o_tw_addr, last_tw);
    chk("inv_hold", o_bf_inv, m);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_bf_ready = 1'b0;
    beats = 0; busy_cyc = 0; dones = 0; last_valid_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    build(0);
    chk("m_f0_a", exp_q[0].a, 0);     chk("m_f0_b", exp_q[0].b, 128);   chk("m_f0_tw", exp_q[0].tw, 1);
    chk("m_f1_b", exp_q[1].b, 129);
    chk("m_f127_a", exp_q[127].a, 127); chk("m_f127_tw", exp_q[127].tw, 1);
    chk("m_l1_a", exp_q[192].a, 128); chk("m_l1_b", exp_q[192].b, 192); chk("m_l1_tw", exp_q[192].tw, 3);
    chk("m_l1b0_tw", exp_q[128].tw, 2);
    chk("m_flast_a", exp_q[895].a, 253); chk("m_flast_b", exp_q[895].b, 255); chk("m_flast_tw", exp_q[895].tw, 127);
    build(1);
    chk("m_i0_b", exp_q[0].b, 2);   chk("m_i0_tw", exp_q[0].tw, 255);
    chk("m_i1_a", exp_q[1].a, 1);   chk("m_i1_b", exp_q[1].b, 3);
    chk("m_ilast_a", exp_q[895].a, 127); chk("m_ilast_tw", exp_q[895].tw, 129);
    exp_q.delete();

    run(0, 0, 926);
    run(1, 0, 926);
    run(0, 1, 936);
    run(1, 2, -1);
    run(0, 2, -1);

    // Abort mid-run with reset, then confirm a fresh run is clean.
    build(0);
    beats = 0; dones = 0;
    i_bf_ready = 1'b1;
    i_mode = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int g = 0; g < 1000 && beats < 300; g++) begin
      @(posedge clk); #1;
    end
    if (beats < 300) chk("abort_reach", beats, 300);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("abort");
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", dones, 0);
    chk("abort_idle", o_busy, 0);
    exp_q.delete();

    run(1, 0, 926);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
